// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage
//   Instruction fetch queue between the fetch PC unit and decode. Each
//   accepted request starts a one-cycle-latency instruction SRAM read. The
//   response is captured into a DEPTH-entry FIFO together with its PC and
//   its address-error and delay-slot tags. The FIFO head is offered to
//   decode through a valid/ready handshake. A single-cycle flush discards
//   queued and in-flight work.
//
// Ports
//   clk, rst          clock and asynchronous active-high reset
//   req_valid/ready   fetch request handshake; pc_next/pc_adel/dsi_in qualify it
//   inst_sram_en      SRAM read strobe (address is pc_next)
//   inst_sram_rdata   SRAM data, returned the cycle after inst_sram_en
//   flush             drop everything, a redirect is pending
//   out_valid/ready   head-of-queue handshake towards decode
//   out_pc, out_pc_add_4, out_inst, out_adel, out_dsi   head entry fields
module fetch_queue_stage #(
  parameter logic [31:0] RESET_ADDR = 32'hbfc00000,
  parameter int          DEPTH      = 4,
  parameter int          PTR_W      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] pc_next,
  input  logic        pc_adel,
  input  logic        dsi_in,
  output logic        inst_sram_en,
  input  logic [31:0] inst_sram_rdata,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_add_4,
  output logic [31:0] out_inst,
  output logic        out_adel,
  output logic        out_dsi
);

  localparam logic [PTR_W+1:0] DEPTH_W = (PTR_W+2)'(DEPTH);

  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             if_v_q, if_v_d;
  logic [31:0]      if_pc_q, if_pc_d;
  logic             if_adel_q, if_adel_d;
  logic             if_dsi_q, if_dsi_d;

  logic [31:0] mem_pc_q   [DEPTH];
  logic [31:0] mem_pc_d   [DEPTH];
  logic [31:0] mem_inst_q [DEPTH];
  logic [31:0] mem_inst_d [DEPTH];
  logic        mem_adel_q [DEPTH];
  logic        mem_adel_d [DEPTH];
  logic        mem_dsi_q  [DEPTH];
  logic        mem_dsi_d  [DEPTH];

  logic             acc;
  logic             push;
  logic             pop;
  logic [PTR_W+1:0] occupancy;

  // Handshake decode: occupancy counts the in-flight read so the FIFO can
  // never be overrun; a same-cycle pop earns no credit.
  always_comb begin
    occupancy    = {1'b0, count_q} + {{(PTR_W+1){1'b0}}, if_v_q};
    req_ready    = ~flush & (occupancy < DEPTH_W);
    acc          = req_valid & req_ready;
    inst_sram_en = acc & ~pc_adel & ~rst;
    out_valid    = (count_q != {(PTR_W+1){1'b0}});
    push         = if_v_q & ~flush;
    pop          = out_valid & out_ready & ~flush;
  end

  // Head entry presentation; PC+4 is derived from the stored PC and wraps.
  always_comb begin
    out_pc       = mem_pc_q[rd_ptr_q];
    out_pc_add_4 = mem_pc_q[rd_ptr_q] + 32'd4;
    out_inst     = mem_inst_q[rd_ptr_q];
    out_adel     = mem_adel_q[rd_ptr_q];
    out_dsi      = mem_dsi_q[rd_ptr_q];
  end

  // Next-state for the in-flight register, pointers and occupancy count.
  always_comb begin
    if_v_d    = acc;
    if_pc_d   = if_pc_q;
    if_adel_d = if_adel_q;
    if_dsi_d  = if_dsi_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (acc) begin
      if_pc_d   = pc_next;
      if_adel_d = pc_adel;
      if_dsi_d  = dsi_in;
    end else begin
      if_pc_d   = if_pc_q;
    end
    if (flush) begin
      if_v_d   = 1'b0;
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {(PTR_W+1){1'b0}};
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + {{PTR_W{1'b0}}, 1'b1};
        2'b01:   count_d = count_q - {{PTR_W{1'b0}}, 1'b1};
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO storage next-state: only the slot at wr_ptr changes, and only on push.
  always_comb begin
    mem_pc_d   = mem_pc_q;
    mem_inst_d = mem_inst_q;
    mem_adel_d = mem_adel_q;
    mem_dsi_d  = mem_dsi_q;
    if (push) begin
      mem_pc_d[wr_ptr_q]   = if_pc_q;
      mem_inst_d[wr_ptr_q] = if_adel_q ? 32'd0 : inst_sram_rdata;
      mem_adel_d[wr_ptr_q] = if_adel_q;
      mem_dsi_d[wr_ptr_q]  = if_dsi_q;
    end else begin
      mem_pc_d[wr_ptr_q]   = mem_pc_q[wr_ptr_q];
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= {(PTR_W+1){1'b0}};
      wr_ptr_q  <= {PTR_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      if_v_q    <= 1'b0;
      if_pc_q   <= RESET_ADDR;
      if_adel_q <= 1'b0;
      if_dsi_q  <= 1'b0;
    end else begin
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      if_v_q    <= if_v_d;
      if_pc_q   <= if_pc_d;
      if_adel_q <= if_adel_d;
      if_dsi_q  <= if_dsi_d;
    end
  end

  // FIFO storage; every slot resets to the boot-vector entry so the idle
  // head shows RESET_ADDR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]   <= RESET_ADDR;
        mem_inst_q[i] <= 32'd0;
        mem_adel_q[i] <= 1'b0;
        mem_dsi_q[i]  <= 1'b0;
      end
    end else begin
      mem_pc_q   <= mem_pc_d;
      mem_inst_q <= mem_inst_d;
      mem_adel_q <= mem_adel_d;
      mem_dsi_q  <= mem_dsi_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Scoreboard bench for fetch_queue_stage. The driver issues requests, plays
// the SRAM (one-cycle read latency) and pushes each expected entry into a
// queue once its data is known. A negedge monitor compares the head and the
// handshake against that queue and pops on every accepted transfer.
module tb_fetch_queue_stage;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] pc_next;
  logic        pc_adel;
  logic        dsi_in;
  logic        inst_sram_en;
  logic [31:0] inst_sram_rdata;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc_add_4;
  logic [31:0] out_inst;
  logic        out_adel;
  logic        out_dsi;

  fetch_queue_stage #(.RESET_ADDR(32'hbfc00000), .DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .pc_next(pc_next), .pc_adel(pc_adel), .dsi_in(dsi_in),
    .inst_sram_en(inst_sram_en), .inst_sram_rdata(inst_sram_rdata),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pc_add_4(out_pc_add_4), .out_inst(out_inst),
    .out_adel(out_adel), .out_dsi(out_dsi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
    logic        dsi;
  } ent_t;

  ent_t exp_q[$];
  ent_t pend_e;
  ent_t s_req;
  bit   pend_v  = 1'b0;
  bit   s_acc   = 1'b0;
  bit   s_flush = 1'b0;
  bit   mon_en  = 1'b0;
  int   checks  = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, want, $time);
    end
  endtask

  // Head and handshake monitor.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
      check("req_ready", {31'd0, req_ready},
            {31'd0, (!flush) && ((exp_q.size() + int'(pend_v)) < DEPTH)});
      if (exp_q.size() != 0) begin
        check("out_pc", out_pc, exp_q[0].pc);
        check("out_pc_add_4", out_pc_add_4, exp_q[0].pc + 32'd4);
        check("out_inst", out_inst, exp_q[0].inst);
        check("out_adel", {31'd0, out_adel}, {31'd0, exp_q[0].adel});
        check("out_dsi", {31'd0, out_dsi}, {31'd0, exp_q[0].dsi});
        if (out_ready && !flush) void'(exp_q.pop_front());
      end
    end
  end

  // One bus cycle: apply the model's view of the last edge, drive, sample.
  task automatic cycle(input bit rv, input logic [31:0] pc, input bit ad,
                       input bit ds, input bit ordy, input bit fl);
    logic [31:0] r;
    @(posedge clk);
    if (s_flush) begin
      exp_q.delete();
      pend_v = 1'b0;
    end else begin
      if (pend_v) exp_q.push_back(pend_e);
      pend_v = s_acc;
      pend_e = s_req;
    end
    #1;
    req_valid = rv; pc_next = pc; pc_adel = ad; dsi_in = ds;
    out_ready = ordy; flush = fl;
    r = $urandom;
    inst_sram_rdata = r;
    if (pend_v && !pend_e.adel) pend_e.inst = r;
    @(negedge clk);
    s_acc   = req_valid && req_ready;
    s_flush = fl;
    s_req   = '{pc: pc, inst: 32'd0, adel: ad, dsi: ds};
    check("inst_sram_en", {31'd0, inst_sram_en}, {31'd0, s_acc && !ad});
  endtask

  task automatic check_reset_head();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_pc", out_pc, 32'hbfc00000);
    check("rst_out_pc_add_4", out_pc_add_4, 32'hbfc00004);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_adel", {31'd0, out_adel}, 32'd0);
    check("rst_out_dsi", {31'd0, out_dsi}, 32'd0);
    check("rst_sram_en", {31'd0, inst_sram_en}, 32'd0);
  endtask

  // Asserts reset mid-cycle with a request pending and rebuilds the model.
  task automatic do_reset();
    mon_en = 1'b0;
    @(posedge clk);
    #3;
    req_valid = 1'b1; pc_next = 32'h00001000; pc_adel = 1'b0; flush = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_head();
    @(posedge clk);
    #1;
    rst = 1'b0; req_valid = 1'b0;
    exp_q.delete();
    pend_v = 1'b0; s_acc = 1'b0; s_flush = 1'b0;
    #1;
    check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    mon_en = 1'b1;
  endtask

  initial begin
    logic [31:0] pc;
    bit          ad;
    rst = 1'b1; req_valid = 1'b0; pc_next = 32'd0; pc_adel = 1'b0;
    dsi_in = 1'b0; inst_sram_rdata = 32'd0; flush = 1'b0; out_ready = 1'b0;
    #2;
    check_reset_head();
    do_reset();

    // Streaming at full rate.
    cycle(1, 32'hbfc00000, 0, 0, 1, 0);
    cycle(1, 32'hbfc00004, 0, 0, 1, 0);
    cycle(1, 32'hbfc00008, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cycle(0, 32'd0, 0, 0, 1, 0);

    // Backpressure: queue fills to DEPTH, then drains in order.
    for (int i = 0; i < 7; i++) cycle(1, 32'h00400000 + 32'(i * 4), 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 32'd0, 0, 0, 1, 0);

    // Flush with two queued entries and one read in flight.
    for (int i = 0; i < 3; i++) cycle(1, 32'h00500000 + 32'(i * 4), 0, 0, 0, 0);
    cycle(1, 32'h0050000c, 0, 0, 0, 1);
    cycle(1, 32'h00600000, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 32'd0, 0, 0, 1, 0);

    // Address error with delay-slot tag, then PC+4 wrap at the top.
    cycle(1, 32'hbfc00002, 1, 1, 1, 0);
    cycle(1, 32'hfffffffc, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 32'd0, 0, 0, 1, 0);

    // Reset with three entries queued.
    for (int i = 0; i < 3; i++) cycle(1, 32'h00700000 + 32'(i * 4), 0, 0, 0, 0);
    cycle(0, 32'd0, 0, 0, 0, 0);
    do_reset();

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      ad = ($urandom_range(7) == 0);
      pc = ($urandom_range(15) == 0) ? 32'hfffffffc : ($urandom & 32'hfffffffc);
      if (ad) pc = pc | 32'd2;
      cycle($urandom_range(3) != 0, pc, ad, $urandom_range(1) == 1,
            $urandom_range(2) != 0, $urandom_range(19) == 0);
    end
    for (int i = 0; i < 8; i++) cycle(0, 32'd0, 0, 0, 1, 0);
    check("drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
- Parametrised successor to the single-register IF/ID latch.
- Issues instruction-SRAM reads and captures each one-cycle-latency response into a DEPTH-entry FIFO, tagged with PC, PC+4, address-error and delay-slot flags.
- Presents the FIFO head to the decode stage with a valid/ready handshake, so fetch and decode decouple under stalls.
- A single-cycle flush discards queued and in-flight entries on branch or exception redirect.

Parameters:
- RESET_ADDR, 32'hbfc00000, PC/fields held in the head entry after reset.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  fetch PC unit offers pc_next this cycle
- req_ready  out  1  request may be accepted this cycle
- pc_next  in  32  fetch address
- pc_adel  in  1  pc_next misaligned (AdEL)
- dsi_in  in  1  the fetched instruction is a delay-slot instruction
- inst_sram_en  out  1  SRAM read strobe, address = pc_next
- inst_sram_rdata  in  32  SRAM data, valid the cycle after inst_sram_en
- flush  in  1  discard everything, redirect pending
- out_valid  out  1  head entry valid
- out_ready  in  1  decode accepts head
- out_pc  out  32  head PC
- out_pc_add_4  out  32  head PC+4, modulo 2^32
- out_inst  out  32  head instruction
- out_adel  out  1  head AdEL tag
- out_dsi  out  1  head delay-slot tag

Behaviour:
- **Accept:** acc = req_valid & req_ready.
  - inst_sram_en = acc & ~pc_adel & ~rst.
  - AdEL requests never touch SRAM.
- **In-flight register:** on acc, the in-flight register latches {pc_next, pc_adel, dsi_in} and sets if_v=1. Otherwise if_v=0. Flush forces if_v=0.
- **Push:** in the cycle if_v=1 and ~flush, one entry is written at wr_ptr:
  - pc = in-flight pc; pc_add_4 = pc+32'd4 (wraps).
  - inst = adel ? 32'd0 : inst_sram_rdata.
  - adel and dsi copied from the in-flight register.
- **Pop:** pop = out_valid & out_ready. Advances rd_ptr.
- **Count:** count (PTR_W+1 bits) += push − pop. Simultaneous push and pop leaves count unchanged.
- **Ready:** req_ready = ~flush & ((count + if_v) < DEPTH).
  - No credit is taken for a same-cycle pop.
  - Overflow is therefore impossible. Throughput is 1/cycle whenever count+if_v ≤ DEPTH−1.
- **Output:** out_valid = (count != 0). out_* driven combinationally from the registered entry at rd_ptr.
  - Head fields must stay stable while out_valid & ~out_ready.
- **Latency:** request accepted in cycle N → entry visible at out_* (out_valid=1) in cycle N+2 if the FIFO was empty.
- **Pointers:** wr_ptr/rd_ptr are PTR_W bits and wrap naturally DEPTH−1→0.
- **Flush (registered effect, next edge):**
  - count=0, wr_ptr=rd_ptr=0, if_v=0.
  - The response arriving in the flush cycle is dropped.
  - A pop coinciding with flush is ignored.
  - req_ready=0 during the flush cycle; new requests are accepted from the following cycle.
- **Reset (async, any time, including mid-stream):**
  - count=0, pointers=0, if_v=0, out_valid=0.
  - Entry 0 = {RESET_ADDR, RESET_ADDR+4, 32'd0, adel=0, dsi=0}, so out_pc=32'hbfc00000, out_pc_add_4=32'hbfc00004, out_inst=0, out_adel=0, out_dsi=0.
  - inst_sram_en=0 while rst=1.
  - Remaining entries need no reset.
- **Entry lifetime:** entry contents are never altered between push and pop.

Test Plan:
- **Reset:** assert rst mid-stream with count=3 → same-cycle out_valid=0, out_pc=32'hbfc00000, out_pc_add_4=32'hbfc00004, out_inst=0; after release req_ready=1.
- **Streaming:** out_ready=1, PCs 0xbfc00000,+4,+8 on consecutive cycles, rdata=0x11,0x22,0x33 → out_valid from cycle 2, entries pop one per cycle in order, out_pc_add_4 = PC+4.
- **Backpressure:** out_ready=0, continuous requests → exactly 4 entries written, req_ready falls to 0 when count+if_v=4; raising out_ready drains in order, no loss or duplication.
- **Flush:** flush asserted while count=2 and if_v=1 → next cycle out_valid=0, count=0, the in-flight rdata is never pushed, req_ready=0 in the flush cycle and 1 after.
- **AdEL and delay slot:** pc_next=0xbfc00002 with pc_adel=1, dsi_in=1 → inst_sram_en=0, entry out_adel=1, out_dsi=1, out_inst=0, out_pc=0xbfc00002.
- **Wrap:** push/pop 10 entries with random out_ready → pointer wrap DEPTH−1→0 correct, and out_pc=0xfffffffc gives out_pc_add_4=0x00000000.
